servo_mmio_ctrl: RTL
====================

// Module: servo_mmio_ctrl
// PURPOSE
//  Memory-mapped peripheral controller between the processor data-memory bus and the servo PWM
//  generator / push button. Decodes I/O word addresses, muxes peripheral read data over RAM read data,
//  ramps the servo duty cycle toward a processor-written target at a programmable rate, and debounces
//  the button into a level plus a sticky press-event flag.
// PARAMETERS
//  CLK_HZ           50_000_000  system clock frequency
//  TICK_HZ          50          ramp update rate (one update per 20 ms servo period)
//  DEBOUNCE_CYCLES  500_000     consecutive stable samples required to accept a button change (10 ms)
//  DUTY_W           10          duty-cycle width in bits
//  DUTY_RESET       0           current/target duty after reset
// PORTS
//  clock        in   1       system clock, all state on posedge
//  reset        in   1       asynchronous, active-high; clears all state
//  mem_addr     in   12      processor data address (word)
//  mem_wren     in   1       processor data write enable
//  mem_data_in  in   32      processor write data
//  ram_q        in   32      data-RAM read data
//  mem_q        out  32      read data to processor (peripheral or RAM)
//  btn_raw      in   1       asynchronous push-button input
//  duty_out     out  DUTY_W  current duty to the servo PWM generator
//  busy         out  1       high while ramping
// BEHAVIOUR
//  Register map (word addr): 7 BTN (R: {31'b0, debounced level}); 11 DUTY (W: target; R: current duty);
//   12 STEP (R/W: ramp step, DUTY_W bits); 13 STAT (R: {30'b0, event, busy}; a read clears event).
//  Writes to any other address have no effect here. mem_q is combinational on mem_addr: a mapped
//   address returns the peripheral value, all others return ram_q.
//  Writes use mem_data_in[DUTY_W-1:0]; upper bits are ignored. Writes to 7 and 13 are ignored.
//  Reset: duty_out = target = DUTY_RESET, step = 1, busy = 0, event = 0, debounced level = 0,
//   tick and debounce counters = 0, FSM = IDLE.
//  Tick: counter runs 0..CLK_HZ/TICK_HZ-1 and wraps; a 1-cycle tick fires at wrap.
//  FSM IDLE: when target != duty_out -> RAMP. If step == 0, duty_out <= target on the next edge
//   and the FSM stays in IDLE.
//  FSM RAMP: on each tick, duty_out moves toward target by min(step, |target-duty_out|), unsigned
//   with no overflow or underflow. RAMP -> IDLE on the edge where duty_out reaches target.
//   busy = (state == RAMP).
//  A target write during RAMP takes effect at the next tick from the current duty_out, and the
//   direction may reverse.
//  A write on the same edge as a tick: the tick uses the old target; the new target is in effect
//   from the next edge.
//  A STEP write mid-ramp applies from the next tick. A write of 0 mid-ramp makes duty_out jump to
//   target on the next edge and returns the FSM to IDLE.
//  Button path: 2-flop synchroniser feeds a stability counter. The counter resets on any change;
//   the debounced level updates once the counter reaches DEBOUNCE_CYCLES.
//  A rising edge of the debounced level sets event. A STAT read (addr 13, mem_wren = 0) clears it.
//   If set and clear occur together, set wins.
//  Reset asserted mid-ramp returns duty_out to DUTY_RESET immediately (asynchronously).
// STRUCTURE
//  Shared package servo_mmio_pkg: address constants (ADDR_BTN = 7, ADDR_DUTY = 11, ADDR_STEP = 12,
//   ADDR_STAT = 13) and the FSM state encoding {IDLE, RAMP}.
//  Sub-module button_debouncer (synchroniser, stability counter, rising-edge pulse).
//  Top level: address decode, read mux, tick counter, ramp FSM.
// TESTING
//  Use reduced parameters: CLK_HZ = 1000, TICK_HZ = 100 (tick every 10 cycles), DEBOUNCE_CYCLES = 4.
//  1. Reset, then write 11 = 100 with step 1 -> busy rises; duty_out +1 per tick; reaches 100
//     after 100 ticks; busy falls on that edge.
//  2. step = 30, target 0 -> 100 -> duty_out 30, 60, 90, 100 on successive ticks; no overshoot.
//  3. Mid-ramp at duty 60, write target 20 -> the next tick gives 30, then 20; FSM returns to IDLE.
//  4. Write step = 0, then target 500 -> duty_out = 500 one edge later; busy never asserts.
//  5. Button: 2-cycle glitch -> no change. 6-cycle press -> read 7 returns 1; read 13 returns
//     bit1 = 1; an immediate re-read returns bit1 = 0.
//  6. Read addr 5 -> mem_q = ram_q. Write addr 7 -> no state change. Reset at duty 60 -> duty_out = 0.

Source files
------------

// File: rtl/servo_mmio_pkg.sv
// Shared definitions for the servo MMIO controller: register word addresses
// and the ramp FSM state type.
package servo_mmio_pkg;

    localparam logic [11:0] ADDR_BTN  = 12'd7;
    localparam logic [11:0] ADDR_DUTY = 12'd11;
    localparam logic [11:0] ADDR_STEP = 12'd12;
    localparam logic [11:0] ADDR_STAT = 12'd13;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

endpackage

// File: rtl/servo_mmio_ctrl_debouncer.sv
// Push-button conditioning: 2-flop synchroniser, stability counter that
// must see DEBOUNCE_CYCLES consecutive differing samples before the
// debounced level follows, and a rising-edge pulse on acceptance.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync2 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept && sync2;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples that differ from the level; any return resets
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_mmio_ctrl.sv
// Memory-mapped servo/button peripheral: address decode, read mux over RAM
// data, tick generator, and a duty-cycle ramp toward a written target.
module servo_mmio_ctrl
    import servo_mmio_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 50,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned DUTY_W          = 10,
    parameter int unsigned DUTY_RESET      = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       mem_addr,
    input  logic              mem_wren,
    input  logic [31:0]       mem_data_in,
    input  logic [31:0]       ram_q,
    output logic [31:0]       mem_q,
    input  logic              btn_raw,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(DUTY_RESET);

    ramp_state_t       state, state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [DUTY_W-1:0] target, step, duty_nxt;
    logic [DUTY_W-1:0] diff, move, toward;
    logic              evt, btn_level, btn_rise;
    logic              wr_duty, wr_step, stat_rd;

    assign wr_duty = mem_wren && (mem_addr == ADDR_DUTY);
    assign wr_step = mem_wren && (mem_addr == ADDR_STEP);
    assign stat_rd = !mem_wren && (mem_addr == ADDR_STAT);
    assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign busy    = (state == RAMP);

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (btn_level),
        .rise    (btn_rise)
    );

    // Free-running tick divider, one-cycle tick at wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // Processor-written target and step registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target <= DUTY_INIT;
            step   <= DUTY_W'(1);
        end else begin
            if (wr_duty) target <= mem_data_in[DUTY_W-1:0];
            if (wr_step) step   <= mem_data_in[DUTY_W-1:0];
        end
    end

    // Sticky press event: a new press wins over a simultaneous STAT read
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         evt <= 1'b0;
        else if (btn_rise) evt <= 1'b1;
        else if (stat_rd)  evt <= 1'b0;
    end

    // Ramp FSM state and current duty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            duty_out <= DUTY_INIT;
        end else begin
            state    <= state_nxt;
            duty_out <= duty_nxt;
        end
    end

    // Next duty: clamp the step to the remaining distance so there is no overshoot
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_out;
        diff      = (target > duty_out) ? (target - duty_out) : (duty_out - target);
        move      = (step < diff) ? step : diff;
        toward    = (target > duty_out) ? (duty_out + move) : (duty_out - move);
        case (state)
            IDLE: begin
                if (target != duty_out) begin
                    if (step == '0) duty_nxt  = target;
                    else            state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (step == '0) begin
                    duty_nxt  = target;
                    state_nxt = IDLE;
                end else if (tick) begin
                    duty_nxt = toward;
                    if (toward == target) state_nxt = IDLE;
                end else if (target == duty_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux: mapped registers override RAM data
    always_comb begin
        case (mem_addr)
            ADDR_BTN:  mem_q = {31'b0, btn_level};
            ADDR_DUTY: mem_q = 32'(duty_out);
            ADDR_STEP: mem_q = 32'(step);
            ADDR_STAT: mem_q = {30'b0, evt, busy};
            default:   mem_q = ram_q;
        endcase
    end

endmodule
